// File: rtl/gemm_row_seq.sv
// Row-sequenced GEMM controller: latches one operand set and walks the accumulator index through an external MAC row.
// Optional macro GEMM_ROW_SEQ_OUT_REG_EN registers o_ele before capture (one extra RUN cycle).
module gemm_row_seq #(
    parameter  int INP_WIDTH = 8,
    parameter  int WGT_WIDTH = 8,
    parameter  int ACC_WIDTH = 32,
    parameter  int INP_DEPTH = 16,
    parameter  int ACC_DEPTH = 16,
    localparam int I_T_WIDTH = INP_WIDTH * INP_DEPTH,
    localparam int W_T_WIDTH = WGT_WIDTH * INP_DEPTH * ACC_DEPTH,
    localparam int A_T_WIDTH = ACC_WIDTH * ACC_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [I_T_WIDTH-1:0] in_row,
    input  logic [W_T_WIDTH-1:0] in_wgt,
    input  logic [A_T_WIDTH-1:0] in_acc,
    output logic [I_T_WIDTH-1:0] i_row,
    output logic [I_T_WIDTH-1:0] w_row,
    output logic [ACC_WIDTH-1:0] a_ele,
    input  logic [ACC_WIDTH-1:0] o_ele,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_T_WIDTH-1:0] out_acc
);

    localparam int IDX_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
    localparam int K_W   = IDX_W + 1;
    localparam logic [K_W-1:0] K_END = K_W'(ACC_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [I_T_WIDTH-1:0] row_q, row_d;
    logic [ACC_DEPTH-1:0][I_T_WIDTH-1:0] wgt_q, wgt_d;
    logic [ACC_DEPTH-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_DEPTH-1:0][ACC_WIDTH-1:0] out_q, out_d;
    logic [IDX_W-1:0] sel;

    // Clamp keeps the drive index in range once k has run past the last element.
    assign sel = (k_q < K_END) ? k_q[IDX_W-1:0] : '0;

    assign i_row   = row_q;
    assign w_row   = wgt_q[sel];
    assign a_ele   = acc_q[sel];
    assign out_acc = out_q;

`ifdef GEMM_ROW_SEQ_OUT_REG_EN
    logic [ACC_WIDTH-1:0] o_reg_q;
    logic [K_W-1:0]       k_m1;
    logic [IDX_W-1:0]     wsel;

    assign k_m1 = k_q - K_W'(1);
    assign wsel = k_m1[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            o_reg_q <= '0;
        end else begin
            o_reg_q <= o_ele;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        wgt_d     = wgt_q;
        acc_d     = acc_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    row_d   = in_row;
                    wgt_d   = in_wgt;
                    acc_d   = in_acc;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                k_d = k_q + K_W'(1);
`ifdef GEMM_ROW_SEQ_OUT_REG_EN
                // Element k-1 lands from the pipeline register while element k is driven.
                if (k_q != '0) begin
                    out_d[wsel] = o_reg_q;
                end
                if (k_q == K_END) begin
                    state_d = DONE;
                end
`else
                out_d[sel] = o_ele;
                if (k_q == K_END - K_W'(1)) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            row_q   <= '0;
            wgt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            wgt_q   <= wgt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_gemm_row_seq.sv
// Scoreboard bench for gemm_row_seq with a behavioural MAC row; honours GEMM_ROW_SEQ_OUT_REG_EN.
module tb_gemm_row_seq;

`ifdef GEMM_ROW_SEQ_OUT_REG_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_row;
    logic [2047:0] in_wgt;
    logic [511:0]  in_acc;
    logic [127:0]  i_row;
    logic [127:0]  w_row;
    logic [31:0]   a_ele;
    logic [31:0]   o_ele;
    logic          out_valid;
    logic          out_ready;
    logic [511:0]  out_acc;

    int n_total = 0;
    int n_pass  = 0;
    logic [511:0] sb[$];
    logic [511:0] mon_exp;

    always #5 clk = ~clk;

    gemm_row_seq #(
        .INP_WIDTH(8), .WGT_WIDTH(8), .ACC_WIDTH(32), .INP_DEPTH(16), .ACC_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_wgt(in_wgt), .in_acc(in_acc),
        .i_row(i_row), .w_row(w_row), .a_ele(a_ele), .o_ele(o_ele),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc)
    );

    function automatic logic [31:0] mac(logic [127:0] r, logic [127:0] w, logic [31:0] a);
        logic [31:0] s;
        s = a;
        for (int j = 0; j < 16; j++) s += 32'(r[j*8 +: 8]) * 32'(w[j*8 +: 8]);
        return s;
    endfunction

    always_comb o_ele = mac(i_row, w_row, a_ele);

    function automatic logic [127:0] fill_row(logic [7:0] v);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[j*8 +: 8] = v;
        return r;
    endfunction

    // Weight row k filled with (k*step + base).
    function automatic logic [2047:0] fill_wgt(logic [7:0] base, logic [7:0] step);
        logic [2047:0] w;
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j++) w[k*128 + j*8 +: 8] = base + step * 8'(k);
        return w;
    endfunction

    function automatic logic [511:0] fill_acc(logic [31:0] base, logic [31:0] step);
        logic [511:0] a;
        for (int k = 0; k < 16; k++) a[k*32 +: 32] = base + step * 32'(k);
        return a;
    endfunction

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_result: actual=%0h required=<none>", out_acc);
            end else begin
                mon_exp = sb.pop_front();
                if (out_acc === mon_exp) n_pass++;
                else $display("FAIL result: actual=%0h required=%0h", out_acc, mon_exp);
            end
        end
    end

    task automatic wait_valid(string name, int exp_lat);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_latency"}, 512'(cnt), 512'(exp_lat));
    endtask

    task automatic run_op(string name, logic [127:0] r, logic [2047:0] w,
                          logic [511:0] a, logic [511:0] exp);
        in_row = r; in_wgt = w; in_acc = a;
        in_valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(name, LAT);
        @(posedge clk); #1;
    endtask

    logic [511:0] e;
    int gap;
    logic seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_row = '0; in_wgt = '0; in_acc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", 512'(in_ready), 512'(1));
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_out_acc", out_acc, '0);
        check("rst_i_row", 512'(i_row), '0);
        check("rst_w_row", 512'(w_row), '0);
        check("rst_a_ele", 512'(a_ele), '0);

        run_op("ones", fill_row(8'd1), fill_wgt(8'd1, 8'd0), '0, fill_acc(32'd16, 32'd0));
        run_op("zero_wgt", fill_row(8'd7), '0, fill_acc(32'd0, 32'd1), fill_acc(32'd0, 32'd1));
        // 16 lanes * 2 * k + 100
        run_op("rowk", fill_row(8'd2), fill_wgt(8'd0, 8'd1), fill_acc(32'd100, 32'd0),
               fill_acc(32'd100, 32'd32));
        // 16 * 255 * 255 = 1040400
        run_op("max", fill_row(8'hFF), fill_wgt(8'hFF, 8'd0), fill_acc(32'd0, 32'd1000),
               fill_acc(32'd1040400, 32'd1000));

        in_row = fill_row(8'd9); in_wgt = fill_wgt(8'd3, 8'd1); in_acc = fill_acc(32'd5, 32'd5);
        for (int i = 0; i < 3; i++) begin
            check("idle_hold_acc", out_acc, fill_acc(32'd1040400, 32'd1000));
            @(posedge clk); #1;
        end

        out_ready = 1'b0;
        e = fill_acc(32'd16, 32'd0);
        in_row = fill_row(8'd1); in_wgt = fill_wgt(8'd1, 8'd0); in_acc = '0;
        in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid("hold", LAT);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 512'(out_valid), 512'(1));
            check("hold_acc", out_acc, e);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_valid", 512'(out_valid), 512'(0));
        check("hold_release_ready", 512'(in_ready), 512'(1));

        in_row = fill_row(8'd4); in_wgt = fill_wgt(8'd4, 8'd0); in_acc = fill_acc(32'd1, 32'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 512'(in_ready), 512'(1));
        check("midrst_out_valid", 512'(out_valid), 512'(0));
        check("midrst_out_acc", out_acc, '0);
        check("midrst_i_row", 512'(i_row), '0);
        check("midrst_w_row", 512'(w_row), '0);
        check("midrst_a_ele", 512'(a_ele), '0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 512'(seen), 512'(0));

        in_row = fill_row(8'd1); in_wgt = fill_wgt(8'd1, 8'd0); in_acc = '0;
        in_valid = 1'b1;
        sb.push_back(fill_acc(32'd16, 32'd0));
        sb.push_back(fill_acc(32'd48, 32'd0));
        @(posedge clk); #1;
        in_row = fill_row(8'd3);
        gap = 0;
        while (!in_ready && gap < 200) begin
            @(posedge clk); #1;
            gap++;
            if (gap == 3) in_row = fill_row(8'd3) ^ 128'h0101;
            if (gap == 5) in_row = fill_row(8'd3);
        end
        @(posedge clk); #1;
        gap++;
        in_valid = 1'b0;
        check("b2b_gap", 512'(gap), 512'(LAT + 2));
        wait_valid("b2b", LAT);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 512'(sb.size()), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gemm_row_seq.md
GEMM_ROW_SEQ -- requirements
Module: gemm_row_seq

Interface
REQ-001 SHALL have parameter INP_WIDTH, default 8, input element width; WGT_WIDTH SHALL equal INP_WIDTH.
REQ-002 SHALL have parameter WGT_WIDTH, default 8, weight element width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, accumulator element width.
REQ-004 SHALL have parameter INP_DEPTH, default 16, elements per input row.
REQ-005 SHALL have parameter ACC_DEPTH, default 16, output elements per operation.
REQ-006 SHALL have derived parameters I_T_WIDTH=INP_WIDTH*INP_DEPTH, W_T_WIDTH=WGT_WIDTH*INP_DEPTH*ACC_DEPTH, A_T_WIDTH=ACC_WIDTH*ACC_DEPTH.
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port in_valid, input, 1, operand set offered.
REQ-010 SHALL have port in_ready, output, 1, operand set accepted when high together with in_valid.
REQ-011 SHALL have port in_row, input, I_T_WIDTH, input row.
REQ-012 SHALL have port in_wgt, input, W_T_WIDTH, weight tile; weight row k at [k*I_T_WIDTH +: I_T_WIDTH].
REQ-013 SHALL have port in_acc, input, A_T_WIDTH, accumulator vector; element k at [k*ACC_WIDTH +: ACC_WIDTH].
REQ-014 SHALL have port i_row, output, I_T_WIDTH, row driven to the MAC row.
REQ-015 SHALL have port w_row, output, I_T_WIDTH, weight row driven to the MAC row.
REQ-016 SHALL have port a_ele, output, ACC_WIDTH, accumulator element driven to the MAC row.
REQ-017 SHALL have port o_ele, input, ACC_WIDTH, combinational result returned by the MAC row.
REQ-018 SHALL have port out_valid, output, 1, result vector available.
REQ-019 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-020 SHALL have port out_acc, output, A_T_WIDTH, result vector; element k at [k*ACC_WIDTH +: ACC_WIDTH].

Function
REQ-021 SHALL implement states IDLE, RUN, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-022 IDLE: on in_valid&in_ready SHALL latch in_row, in_wgt, in_acc, clear index k to 0, go to RUN.
REQ-023 Latched operands SHALL remain stable through RUN/DONE regardless of input port changes.
REQ-024 i_row SHALL be the latched row; w_row and a_ele SHALL be latched weight row k and accumulator element k, k taken from the registered index.
REQ-025 RUN: each cycle SHALL write o_ele into out_acc element k and increment k; after writing k=ACC_DEPTH-1 SHALL go to DONE.
REQ-026 Latency from accepting edge to out_valid high SHALL be exactly ACC_DEPTH cycles (REQ-034 excepted).
REQ-027 DONE: out_valid and out_acc SHALL hold until out_valid&out_ready, then go to IDLE on that edge.
REQ-028 out_ready while not in DONE SHALL be ignored; in_valid while not in IDLE SHALL be ignored (not latched).
REQ-029 Back-to-back operations SHALL have no overlap; minimum cycles between accepts is ACC_DEPTH+2.
REQ-030 out_acc SHALL not change in IDLE; new elements overwrite only during RUN.

Reset
REQ-031 rst high at any edge, including mid-RUN or in DONE, SHALL force IDLE, k=0, out_valid=0, in_ready=1 next cycle.
REQ-032 Reset SHALL clear out_acc and all latched operands to 0, so i_row, w_row, a_ele read 0 after reset.
REQ-033 An operation interrupted by reset SHALL produce no out_valid.

Configuration
REQ-034 With macro GEMM_ROW_SEQ_OUT_REG_EN defined, o_ele SHALL be registered before capture: element k written one cycle after its drive, RUN lasts ACC_DEPTH+1 cycles, latency ACC_DEPTH+1; without it, capture is same-cycle per REQ-025.

Verification
REQ-035 in_row all 1, in_wgt all 1, in_acc all 0 with behavioural MAC row -> out_acc every element 16, out_valid after 16 cycles.
REQ-036 in_wgt all 0, in_acc element k = k -> out_acc element k = k for k=0..15.
REQ-037 out_ready low 5 cycles in DONE -> out_valid and out_acc stable 5 cycles, IDLE one cycle after out_ready high.
REQ-038 rst pulsed when k=7 -> next cycle IDLE, out_acc=0, out_valid never asserts for that operation.
REQ-039 in_valid held high through RUN with changing in_row -> second operation accepted only after DONE handshake; first result uses original operands.
REQ-040 Same as REQ-035 with GEMM_ROW_SEQ_OUT_REG_EN defined -> identical out_acc, out_valid after 17 cycles.
